opctrl_receive_fsm: RTL and testbench
=====================================

// Module: opctrl_receive_fsm
// PURPOSE
//  Collects a stream of DATA_W-bit read words into one operand set: A, B and a
//  double-width C (low word, then high word).
//  Raises a one-cycle operation_valid_o when the set is complete.
//  Sits between the read-data/FIFO interface and the operation (execute) unit.
//  Input words have no backpressure; every valid word is accepted.
// PARAMETERS
//  DATA_W    20         width of data_t (one read word, operands A and B)
//  W_DATA_W  2*DATA_W   width of w_data_t (operand C)
// PORTS
//  clk                in   1         single clock, all logic on rising edge
//  rst_i              in   1         synchronous, active-high reset
//  rd_data_valid_i    in   1         rd_data_i holds a word this cycle
//  rd_data_i          in   DATA_W    incoming word
//  operand_a_o        out  DATA_W    registered operand A
//  operand_b_o        out  DATA_W    registered operand B
//  operand_c_o        out  W_DATA_W  registered operand C = {hi_word, lo_word}
//  operation_valid_o  out  1         1-cycle pulse: operand outputs hold a new set
//  op_count_o         out  16        completed-set counter (only with macro, see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst_i=1 at posedge): state=RX_A.
//   - operand_a_o, operand_b_o, operand_c_o, shadow regs = 0.
//   - operation_valid_o = 0.
//   - Any partial set is discarded.
//  FSM states RX_A -> RX_B -> RX_C_LO -> RX_C_HI -> RX_A.
//   - The state advances only on a cycle with rd_data_valid_i=1.
//   - With rd_data_valid_i=0 the state and shadow regs hold; gaps are allowed anywhere.
//  Capture per accepted word:
//   - RX_A: shadow_a = rd_data_i.
//   - RX_B: shadow_b = rd_data_i.
//   - RX_C_LO: shadow_c_lo = rd_data_i.
//   - RX_C_HI: all outputs update together at that posedge:
//     operand_a_o = shadow_a, operand_b_o = shadow_b,
//     operand_c_o = {rd_data_i, shadow_c_lo}, operation_valid_o = 1.
//  Latency: outputs and the pulse appear at the same edge that samples the 4th word.
//   - The pulse lasts exactly one cycle.
//  Between sets, operand outputs hold their last values; they never show a partial set.
//  Back-to-back sets: a word valid in the cycle the pulse is high is taken as the
//   next A with no bubble. Sustained throughput is one set per 4 valid cycles.
//  Arithmetic: none; pure concatenation, no sign or zero extension beyond the above.
//  rd_data_i is don't-care when rd_data_valid_i=0.
// CONFIGURATION
//  Macro RECEIVE_FSM_OP_COUNT_EN:
//   - Defined: port op_count_o exists. It resets to 0 and increments when
//     operation_valid_o is set; it wraps 16'hFFFF -> 0.
//   - Undefined: the port and its counter are absent; all other behaviour is identical.
// STRUCTURE
//  config_pkg (shared): DATA_W, W_DATA_W, typedef data_t [DATA_W-1:0],
//   typedef w_data_t [W_DATA_W-1:0].
//  FSM state enum is local to the module.
//  Single flat module; no sub-module.
// TESTING
//  1. Reset held 2 cycles -> all outputs 0, operation_valid_o 0; after release,
//     outputs stay 0 with no valid words.
//  2. Valid words ABCDE, DEADF, CAFEA, FADED on consecutive cycles -> one pulse at
//     the 4th edge with a=20'hABCDE, b=20'hDEADF, c=40'hFADEDCAFEA.
//  3. Immediately following CBBDE, FBAAE, DEADF, CAFEA (no gap) -> pulse exactly 4
//     cycles after the previous one, a=CBBDE, b=FBAAE, c=40'hCAFEADEADF; outputs
//     unchanged between the pulses.
//  4. Valid held high with constant FADED for 20 cycles -> pulse every 4th cycle,
//     a=b=FADED, c=40'hFADEDFADED.
//  5. Words 11111 and 22222, then 3 idle cycles, then 33333 and 44444 -> single pulse
//     on the last edge with c=40'h4444433333; no pulse during the gap.
//  6. rst_i asserted after 2 words, then 4 new words -> the first set is discarded and
//     the pulse carries only the new words; with RECEIVE_FSM_OP_COUNT_EN defined,
//     op_count_o increments once per pulse and is 0 after reset.

Source files
------------

// File: rtl/config_pkg.sv
// Shared datapath widths and word types for the operation-control block.
package config_pkg;

    localparam int DATA_W   = 20;
    localparam int W_DATA_W = 2 * DATA_W;

    typedef logic [DATA_W-1:0]   data_t;
    typedef logic [W_DATA_W-1:0] w_data_t;

endpackage : config_pkg

// File: rtl/opctrl_receive_fsm.sv
// Assembles A, B and double-width C (lo then hi word) from the read-word stream into one operand set.
// Latency: outputs and operation_valid_o update on the edge that samples the 4th word; pulse lasts 1 cycle.
// No backpressure: every valid word is taken. Optional op_count_o under macro RECEIVE_FSM_OP_COUNT_EN.
module opctrl_receive_fsm
    import config_pkg::*;
(
    input  logic        clk,
    input  logic        rst_i,
    input  logic        rd_data_valid_i,
    input  data_t       rd_data_i,
    output data_t       operand_a_o,
    output data_t       operand_b_o,
    output w_data_t     operand_c_o,
    output logic        operation_valid_o
`ifdef RECEIVE_FSM_OP_COUNT_EN
    ,
    output logic [15:0] op_count_o
`endif
);

    typedef enum logic [1:0] {
        RX_A    = 2'd0,
        RX_B    = 2'd1,
        RX_C_LO = 2'd2,
        RX_C_HI = 2'd3
    } rx_state_t;

    rx_state_t state_q;
    rx_state_t state_d;
    logic      set_done;

    data_t shadow_a;
    data_t shadow_b;
    data_t shadow_c_lo;

    always_comb begin
        state_d  = state_q;
        set_done = 1'b0;
        if (rd_data_valid_i) begin
            unique case (state_q)
                RX_A:    state_d = RX_B;
                RX_B:    state_d = RX_C_LO;
                RX_C_LO: state_d = RX_C_HI;
                RX_C_HI: begin
                    state_d  = RX_A;
                    set_done = 1'b1;
                end
                default: state_d = RX_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q <= RX_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Shadows hold the partial set so the visible operands never change mid-set.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            shadow_a    <= '0;
            shadow_b    <= '0;
            shadow_c_lo <= '0;
        end else if (rd_data_valid_i) begin
            unique case (state_q)
                RX_A:    shadow_a    <= rd_data_i;
                RX_B:    shadow_b    <= rd_data_i;
                RX_C_LO: shadow_c_lo <= rd_data_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            operand_a_o       <= '0;
            operand_b_o       <= '0;
            operand_c_o       <= '0;
            operation_valid_o <= 1'b0;
        end else begin
            operation_valid_o <= set_done;
            if (set_done) begin
                operand_a_o <= shadow_a;
                operand_b_o <= shadow_b;
                operand_c_o <= {rd_data_i, shadow_c_lo};
            end
        end
    end

`ifdef RECEIVE_FSM_OP_COUNT_EN
    // Counts on the same edge that raises the pulse; wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            op_count_o <= '0;
        end else if (set_done) begin
            op_count_o <= op_count_o + 16'd1;
        end
    end
`endif

endmodule : opctrl_receive_fsm

// File: tb/tb_opctrl_receive_fsm.sv
// Directed self-checking bench for opctrl_receive_fsm; covers reset, back-to-back sets, gaps and mid-set reset.
module tb_opctrl_receive_fsm;
    import config_pkg::*;

    logic        clk;
    logic        rst_i;
    logic        rd_data_valid_i;
    data_t       rd_data_i;
    data_t       operand_a_o;
    data_t       operand_b_o;
    w_data_t     operand_c_o;
    logic        operation_valid_o;
`ifdef RECEIVE_FSM_OP_COUNT_EN
    logic [15:0] op_count_o;
    logic [15:0] exp_cnt;
`endif

    int n_checks;
    int n_errors;

    opctrl_receive_fsm dut (
        .clk               (clk),
        .rst_i             (rst_i),
        .rd_data_valid_i   (rd_data_valid_i),
        .rd_data_i         (rd_data_i),
        .operand_a_o       (operand_a_o),
        .operand_b_o       (operand_b_o),
        .operand_c_o       (operand_c_o),
        .operation_valid_o (operation_valid_o)
`ifdef RECEIVE_FSM_OP_COUNT_EN
        ,
        .op_count_o        (op_count_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of input, then sample 1 ns after the edge.
    task automatic step(input logic vld, input data_t dat);
        rd_data_valid_i = vld;
        rd_data_i       = dat;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic pulse, input data_t a,
                            input data_t b, input w_data_t c);
        chk({tag, "_vld"}, 64'(operation_valid_o), 64'(pulse));
        chk({tag, "_a"},   64'(operand_a_o),       64'(a));
        chk({tag, "_b"},   64'(operand_b_o),       64'(b));
        chk({tag, "_c"},   64'(operand_c_o),       64'(c));
`ifdef RECEIVE_FSM_OP_COUNT_EN
        if (pulse) exp_cnt = exp_cnt + 16'd1;
        chk({tag, "_cnt"}, 64'(op_count_o), 64'(exp_cnt));
`endif
    endtask

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        rst_i           = 1'b1;
        rd_data_valid_i = 1'b0;
        rd_data_i       = '0;
`ifdef RECEIVE_FSM_OP_COUNT_EN
        exp_cnt         = 16'd0;
`endif

        // 1. reset for two cycles, then idle
        step(1'b0, 20'h12345);
        step(1'b1, 20'h12345);
        chk_outs("reset", 1'b0, 20'h0, 20'h0, 40'h0);
        rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 20'hFFFFF);
            chk_outs("idle", 1'b0, 20'h0, 20'h0, 40'h0);
        end

        // 2. first set; outputs stay zero until the 4th word
        step(1'b1, 20'hABCDE); chk_outs("s1_w1", 1'b0, 20'h0, 20'h0, 40'h0);
        step(1'b1, 20'hDEADF); chk_outs("s1_w2", 1'b0, 20'h0, 20'h0, 40'h0);
        step(1'b1, 20'hCAFEA); chk_outs("s1_w3", 1'b0, 20'h0, 20'h0, 40'h0);
        step(1'b1, 20'hFADED); chk_outs("s1_w4", 1'b1, 20'hABCDE, 20'hDEADF, 40'hFADEDCAFEA);

        // 3. back-to-back set, previous values held until the new pulse
        step(1'b1, 20'hCBBDE); chk_outs("s2_w1", 1'b0, 20'hABCDE, 20'hDEADF, 40'hFADEDCAFEA);
        step(1'b1, 20'hFBAAE); chk_outs("s2_w2", 1'b0, 20'hABCDE, 20'hDEADF, 40'hFADEDCAFEA);
        step(1'b1, 20'hDEADF); chk_outs("s2_w3", 1'b0, 20'hABCDE, 20'hDEADF, 40'hFADEDCAFEA);
        step(1'b1, 20'hCAFEA); chk_outs("s2_w4", 1'b1, 20'hCBBDE, 20'hFBAAE, 40'hCAFEADEADF);

        // 4. sustained stream of FADED: pulse every 4th cycle
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 20'hFADED);
            if (i < 3)
                chk_outs("stream", 1'b0, 20'hCBBDE, 20'hFBAAE, 40'hCAFEADEADF);
            else
                chk_outs("stream", (i % 4) == 3, 20'hFADED, 20'hFADED, 40'hFADEDFADED);
        end

        // 5. gap in the middle of a set
        step(1'b1, 20'h11111); chk_outs("gap_w1", 1'b0, 20'hFADED, 20'hFADED, 40'hFADEDFADED);
        step(1'b1, 20'h22222); chk_outs("gap_w2", 1'b0, 20'hFADED, 20'hFADED, 40'hFADEDFADED);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 20'h99999);
            chk_outs("gap_idle", 1'b0, 20'hFADED, 20'hFADED, 40'hFADEDFADED);
        end
        step(1'b1, 20'h33333); chk_outs("gap_w3", 1'b0, 20'hFADED, 20'hFADED, 40'hFADEDFADED);
        step(1'b1, 20'h44444); chk_outs("gap_w4", 1'b1, 20'h11111, 20'h22222, 40'h4444433333);

        // 6. reset after two words discards the partial set
        step(1'b1, 20'h55555); chk_outs("rst_w1", 1'b0, 20'h11111, 20'h22222, 40'h4444433333);
        step(1'b1, 20'h66666); chk_outs("rst_w2", 1'b0, 20'h11111, 20'h22222, 40'h4444433333);
        rst_i = 1'b1;
        step(1'b0, 20'h0);
`ifdef RECEIVE_FSM_OP_COUNT_EN
        exp_cnt = 16'd0;
`endif
        chk_outs("rst_mid", 1'b0, 20'h0, 20'h0, 40'h0);
        rst_i = 1'b0;
        step(1'b1, 20'h77777); chk_outs("new_w1", 1'b0, 20'h0, 20'h0, 40'h0);
        step(1'b1, 20'h88888); chk_outs("new_w2", 1'b0, 20'h0, 20'h0, 40'h0);
        step(1'b1, 20'h99999); chk_outs("new_w3", 1'b0, 20'h0, 20'h0, 40'h0);
        step(1'b1, 20'hAAAAA); chk_outs("new_w4", 1'b1, 20'h77777, 20'h88888, 40'hAAAAA99999);
        step(1'b0, 20'h0);     chk_outs("new_end", 1'b0, 20'h77777, 20'h88888, 40'hAAAAA99999);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_opctrl_receive_fsm
